// File: rtl/mc_control_unit_hs.sv
// mc_control_unit_hs
//   Multicycle RV32I control FSM. It decodes the instruction register's opcode/funct7
//   and sequences the multicycle datapath through its fetch, decode, execute, memory
//   and writeback steps.
//   Additional features:
//     - a memory ready handshake on fetch and on data accesses
//     - optional RV32M (MDU) sequencing with a start pulse and a done wait
//     - an illegal-opcode trap, optionally parking the FSM in HALT
//     - a retired-instruction counter
// Ports
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   instruction_opcode/funct7       IR[6:0] / IR[31:25], sampled in DECODE and MEMADR only
//   mem_ready                       memory access completes this cycle
//   mdu_done                        MDU result valid (level), looked at only in MDU_WAIT
//   pc_write ... memory_to_reg      1-bit datapath enables/selects
//   aluop, alu_src_a, alu_src_b     2-bit datapath selects
//   mdu_start                       one-cycle MDU launch pulse
//   illegal_instr                   one-cycle trap flag
//   halted                          FSM parked in HALT
//   instret                         retired-instruction count (wraps)
module mc_control_unit_hs #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit ENABLE_MDU    = 1'b1,
  parameter bit TRAP_HALT     = 1'b0,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       instruction_opcode,
  input  logic [6:0]       instruction_funct7,
  input  logic             mem_ready,
  input  logic             mdu_done,
  output logic             pc_write,
  output logic             ir_write,
  output logic             pc_source,
  output logic             reg_write,
  output logic             memory_read,
  output logic             memory_write,
  output logic             is_immediate,
  output logic             pc_write_cond,
  output logic             lorD,
  output logic             memory_to_reg,
  output logic [1:0]       aluop,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mdu_start,
  output logic             illegal_instr,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_MDU   = 7'b0000001;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_ALUWB, S_ADDI_EXEC, S_ADDI_WB, S_BRANCH,
    S_LUI_EXEC, S_LUI_WB, S_AUIPC_EXEC, S_AUIPC_WB,
    S_JAL_EXEC, S_JAL_WB, S_JALR_EXEC, S_JALR_WB,
    S_MDU_EXEC, S_MDU_WAIT, S_TRAP, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       pc_source;
    logic       reg_write;
    logic       memory_read;
    logic       memory_write;
    logic       is_immediate;
    logic       pc_write_cond;
    logic       lord;
    logic       memory_to_reg;
    logic [1:0] aluop;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       mdu_start;
    logic       illegal_instr;
    logic       halted;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  ctrl_t            ctrl_c, ctrl_o;
  logic             retire;
  logic             mem_rdy;

  assign mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.memory_read = 1'b1;
        ctrl_c.alu_src_b   = 2'b01;
        // IR load and PC+4 only commit on the cycle the memory delivers the word.
        if (mem_rdy) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target (oldPC + imm) is precomputed here for BRANCH.
        ctrl_c.alu_src_a = 2'b10;
        ctrl_c.alu_src_b = 2'b10;
        case (instruction_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (ENABLE_MDU && instruction_funct7 == F7_MDU) ? S_MDU_EXEC
                                                                               : S_EXECUTER;
          OP_BR:        state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_LUI:       state_d = S_LUI_EXEC;
          OP_JAL:       state_d = S_JAL_EXEC;
          OP_JALR:      state_d = S_JALR_EXEC;
          OP_AUIPC:     state_d = S_AUIPC_EXEC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl_c.alu_src_a = 2'b01;
        ctrl_c.alu_src_b = 2'b10;
        state_d = (instruction_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl_c.memory_read = 1'b1;
        ctrl_c.lord        = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl_c.reg_write     = 1'b1;
        ctrl_c.memory_to_reg = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_c.memory_write = 1'b1;
        ctrl_c.lord         = 1'b1;
        if (mem_rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTER: begin
        ctrl_c.alu_src_a = 2'b01;
        ctrl_c.aluop     = 2'b10;
        state_d = S_ALUWB;
      end
      S_ADDI_EXEC: begin
        ctrl_c.alu_src_a    = 2'b01;
        ctrl_c.alu_src_b    = 2'b10;
        ctrl_c.aluop        = 2'b10;
        ctrl_c.is_immediate = 1'b1;
        state_d = S_ADDI_WB;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 2'b01;
        ctrl_c.aluop         = 2'b01;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_LUI_EXEC: begin
        ctrl_c.alu_src_a = 2'b11;
        ctrl_c.alu_src_b = 2'b10;
        state_d = S_LUI_WB;
      end
      S_AUIPC_EXEC: begin
        ctrl_c.alu_src_a = 2'b10;
        ctrl_c.alu_src_b = 2'b10;
        state_d = S_AUIPC_WB;
      end
      S_JAL_EXEC: begin
        ctrl_c.alu_src_a = 2'b10;
        ctrl_c.alu_src_b = 2'b01;
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = 1'b1;
        state_d = S_JAL_WB;
      end
      S_JALR_EXEC: begin
        ctrl_c.alu_src_a    = 2'b01;
        ctrl_c.alu_src_b    = 2'b10;
        ctrl_c.is_immediate = 1'b1;
        state_d = S_JALR_WB;
      end
      S_JALR_WB: begin
        ctrl_c.alu_src_a = 2'b10;
        ctrl_c.alu_src_b = 2'b01;
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ALUWB, S_ADDI_WB, S_LUI_WB, S_AUIPC_WB, S_JAL_WB: begin
        ctrl_c.reg_write = 1'b1;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MDU_EXEC: begin
        ctrl_c.mdu_start = 1'b1;
        state_d = S_MDU_WAIT;
      end
      S_MDU_WAIT: begin
        if (mdu_done) state_d = S_ALUWB;
      end
      S_TRAP: begin
        ctrl_c.illegal_instr = 1'b1;
        state_d = TRAP_HALT ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        ctrl_c.halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  assign instret   = instret_q;

  // Reset forces FETCH, whose decode would drive memory_read; mask every control
  // while rst_n is low so the datapath sees an idle unit.
  assign ctrl_o = rst_n ? ctrl_c : '0;

  assign pc_write      = ctrl_o.pc_write;
  assign ir_write      = ctrl_o.ir_write;
  assign pc_source     = ctrl_o.pc_source;
  assign reg_write     = ctrl_o.reg_write;
  assign memory_read   = ctrl_o.memory_read;
  assign memory_write  = ctrl_o.memory_write;
  assign is_immediate  = ctrl_o.is_immediate;
  assign pc_write_cond = ctrl_o.pc_write_cond;
  assign lorD          = ctrl_o.lord;
  assign memory_to_reg = ctrl_o.memory_to_reg;
  assign aluop         = ctrl_o.aluop;
  assign alu_src_a     = ctrl_o.alu_src_a;
  assign alu_src_b     = ctrl_o.alu_src_b;
  assign mdu_start     = ctrl_o.mdu_start;
  assign illegal_instr = ctrl_o.illegal_instr;
  assign halted        = ctrl_o.halted;

endmodule

// File: tb/tb_mc_control_unit_hs.sv
// tb_mc_control_unit_hs
//   Directed bench for mc_control_unit_hs. Two instances share the stimulus:
//   dut0 uses the default parameters, and dut1 uses ENABLE_MDU=0, TRAP_HALT=1, CNT_W=4.
//   The control outputs are packed into one word per instance and compared per cycle
//   against hand-built expected words.
module tb_mc_control_unit_hs;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  // {pc_write, ir_write, pc_source, reg_write, memory_read, memory_write, is_immediate,
  //  pc_write_cond, lorD, memory_to_reg}, aluop, alu_src_a, alu_src_b, {mdu_start, illegal, halted}
  localparam logic [18:0] C_ZERO       = 19'd0;
  localparam logic [18:0] C_FETCH_WAIT = {10'b0000100000, 2'b00, 2'b00, 2'b01, 3'b000};
  localparam logic [18:0] C_FETCH_GO   = {10'b1100100000, 2'b00, 2'b00, 2'b01, 3'b000};
  localparam logic [18:0] C_DECODE     = {10'b0000000000, 2'b00, 2'b10, 2'b10, 3'b000};
  localparam logic [18:0] C_MEMADR     = {10'b0000000000, 2'b00, 2'b01, 2'b10, 3'b000};
  localparam logic [18:0] C_MEMREAD    = {10'b0000100010, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_MEMWB      = {10'b0001000001, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_MEMWRITE   = {10'b0000010010, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_EXECR      = {10'b0000000000, 2'b10, 2'b01, 2'b00, 3'b000};
  localparam logic [18:0] C_WB         = {10'b0001000000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] C_ADDI_EX    = {10'b0000001000, 2'b10, 2'b01, 2'b10, 3'b000};
  localparam logic [18:0] C_BRANCH     = {10'b0010000100, 2'b01, 2'b01, 2'b00, 3'b000};
  localparam logic [18:0] C_LUI_EX     = {10'b0000000000, 2'b00, 2'b11, 2'b10, 3'b000};
  localparam logic [18:0] C_AUIPC_EX   = {10'b0000000000, 2'b00, 2'b10, 2'b10, 3'b000};
  localparam logic [18:0] C_JAL_EX     = {10'b1010000000, 2'b00, 2'b10, 2'b01, 3'b000};
  localparam logic [18:0] C_JALR_EX    = {10'b0000001000, 2'b00, 2'b01, 2'b10, 3'b000};
  localparam logic [18:0] C_JALR_WB    = {10'b1010000000, 2'b00, 2'b10, 2'b01, 3'b000};
  localparam logic [18:0] C_MDU_START  = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b100};
  localparam logic [18:0] C_TRAP       = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b010};
  localparam logic [18:0] C_HALT       = {10'b0000000000, 2'b00, 2'b00, 2'b00, 3'b001};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode, funct7;
  logic       mem_ready, mdu_done;

  logic        pcw0, irw0, pcs0, rw0, mr0, mw0, imm0, pwc0, lord0, m2r0, ms0, ill0, hlt0;
  logic [1:0]  aluop0, a0, b0;
  logic [31:0] instret0;
  logic        pcw1, irw1, pcs1, rw1, mr1, mw1, imm1, pwc1, lord1, m2r1, ms1, ill1, hlt1;
  logic [1:0]  aluop1, a1, b1;
  logic [3:0]  instret1;
  logic [18:0] ctrl0, ctrl1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_control_unit_hs dut0 (
    .clk(clk), .rst_n(rst_n),
    .instruction_opcode(opcode), .instruction_funct7(funct7),
    .mem_ready(mem_ready), .mdu_done(mdu_done),
    .pc_write(pcw0), .ir_write(irw0), .pc_source(pcs0), .reg_write(rw0),
    .memory_read(mr0), .memory_write(mw0), .is_immediate(imm0), .pc_write_cond(pwc0),
    .lorD(lord0), .memory_to_reg(m2r0), .aluop(aluop0), .alu_src_a(a0), .alu_src_b(b0),
    .mdu_start(ms0), .illegal_instr(ill0), .halted(hlt0), .instret(instret0)
  );

  mc_control_unit_hs #(.ENABLE_MDU(1'b0), .TRAP_HALT(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .instruction_opcode(opcode), .instruction_funct7(funct7),
    .mem_ready(mem_ready), .mdu_done(mdu_done),
    .pc_write(pcw1), .ir_write(irw1), .pc_source(pcs1), .reg_write(rw1),
    .memory_read(mr1), .memory_write(mw1), .is_immediate(imm1), .pc_write_cond(pwc1),
    .lorD(lord1), .memory_to_reg(m2r1), .aluop(aluop1), .alu_src_a(a1), .alu_src_b(b1),
    .mdu_start(ms1), .illegal_instr(ill1), .halted(hlt1), .instret(instret1)
  );

  assign ctrl0 = {pcw0, irw0, pcs0, rw0, mr0, mw0, imm0, pwc0, lord0, m2r0,
                  aluop0, a0, b0, ms0, ill0, hlt0};
  assign ctrl1 = {pcw1, irw1, pcs1, rw1, mr1, mw1, imm1, pwc1, lord1, m2r1,
                  aluop1, a1, b1, ms1, ill1, hlt1};

  typedef struct {
    logic [6:0]  op;
    logic [6:0]  f7;
    logic        mr;
    logic        md;
    logic [18:0] exp_ctrl;
    logic [31:0] exp_instret;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [6:0] op, input logic [6:0] f7, input logic mr,
                     input logic md, input logic [18:0] ec, input logic [31:0] ei);
    vec_t v;
    v.op = op; v.f7 = f7; v.mr = mr; v.md = md; v.exp_ctrl = ec; v.exp_instret = ei;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: the posedge consumes the previous inputs, new inputs are applied
  // just after it, and outputs are sampled on the following negedge.
  task automatic step(input logic [6:0] op, input logic [6:0] f7, input logic mr, input logic md);
    @(posedge clk);
    #1;
    opcode = op; funct7 = f7; mem_ready = mr; mdu_done = md;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    mem_ready = 1'b0; mdu_done = 1'b0; opcode = OP_ADDI; funct7 = 7'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, ills, halts;
    rst_n = 1'b0; opcode = OP_ADDI; funct7 = 7'd0; mem_ready = 1'b1; mdu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // mem_ready=1 in FETCH would assert memory_read/ir_write/pc_write if not masked
    chk("reset_ctrl0", 32'(ctrl0), 32'(C_ZERO));
    chk("reset_ctrl1", 32'(ctrl1), 32'(C_ZERO));
    chk("reset_instret0", instret0, 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI with junk opcode / mdu_done in non-sampling states
    add(OP_ADDI, 7'd0, 1, 0, C_FETCH_GO, 0);
    add(OP_ADDI, 7'd0, 1, 0, C_DECODE,   0);
    add(OP_BAD,  7'd0, 1, 1, C_ADDI_EX,  0);
    add(OP_BAD,  7'd0, 0, 0, C_WB,       0);
    // FETCH stalled twice, then LW with 3 stall cycles in MEMREAD
    add(OP_LW, 7'd0, 0, 0, C_FETCH_WAIT, 1);
    add(OP_LW, 7'd0, 0, 0, C_FETCH_WAIT, 1);
    add(OP_LW, 7'd0, 1, 0, C_FETCH_GO,   1);
    add(OP_LW, 7'd0, 0, 0, C_DECODE,     1);
    add(OP_LW, 7'd0, 1, 0, C_MEMADR,     1);
    add(OP_LW, 7'd0, 0, 0, C_MEMREAD,    1);
    add(OP_LW, 7'd0, 0, 0, C_MEMREAD,    1);
    add(OP_LW, 7'd0, 0, 0, C_MEMREAD,    1);
    add(OP_LW, 7'd0, 1, 0, C_MEMREAD,    1);
    add(OP_LW, 7'd0, 1, 0, C_MEMWB,      1);
    // SW with one stall in MEMWRITE
    add(OP_SW, 7'd0, 1, 0, C_FETCH_GO, 2);
    add(OP_SW, 7'd0, 1, 0, C_DECODE,   2);
    add(OP_SW, 7'd0, 1, 0, C_MEMADR,   2);
    add(OP_SW, 7'd0, 0, 0, C_MEMWRITE, 2);
    add(OP_SW, 7'd0, 1, 0, C_MEMWRITE, 2);
    // Branch: 3 cycles
    add(OP_BR, 7'd0, 1, 0, C_FETCH_GO, 3);
    add(OP_BR, 7'd0, 1, 0, C_DECODE,   3);
    add(OP_BR, 7'd0, 1, 0, C_BRANCH,   3);
    // R-type (SUB), mdu_done outside MDU_WAIT ignored
    add(OP_RTYPE, 7'b0100000, 1, 0, C_FETCH_GO, 4);
    add(OP_RTYPE, 7'b0100000, 1, 0, C_DECODE,   4);
    add(OP_RTYPE, 7'b0100000, 1, 1, C_EXECR,    4);
    add(OP_RTYPE, 7'b0100000, 1, 1, C_WB,       4);
    add(OP_LUI,   7'd0, 1, 0, C_FETCH_GO, 5);
    add(OP_LUI,   7'd0, 1, 0, C_DECODE,   5);
    add(OP_LUI,   7'd0, 1, 0, C_LUI_EX,   5);
    add(OP_LUI,   7'd0, 1, 0, C_WB,       5);
    add(OP_AUIPC, 7'd0, 1, 0, C_FETCH_GO, 6);
    add(OP_AUIPC, 7'd0, 1, 0, C_DECODE,   6);
    add(OP_AUIPC, 7'd0, 1, 0, C_AUIPC_EX, 6);
    add(OP_AUIPC, 7'd0, 1, 0, C_WB,       6);
    add(OP_JAL,   7'd0, 1, 0, C_FETCH_GO, 7);
    add(OP_JAL,   7'd0, 1, 0, C_DECODE,   7);
    add(OP_JAL,   7'd0, 1, 0, C_JAL_EX,   7);
    add(OP_JAL,   7'd0, 1, 0, C_WB,       7);
    add(OP_JALR,  7'd0, 1, 0, C_FETCH_GO, 8);
    add(OP_JALR,  7'd0, 1, 0, C_DECODE,   8);
    add(OP_JALR,  7'd0, 1, 0, C_JALR_EX,  8);
    add(OP_JALR,  7'd0, 1, 0, C_JALR_WB,  8);

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].f7, vecs[i].mr, vecs[i].md);
      $display("vec %0d op=%b mr=%b ctrl0=%h ctrl1=%h instret0=%0d", i, vecs[i].op,
               vecs[i].mr, ctrl0, ctrl1, instret0);
      chk($sformatf("vec%0d_ctrl0", i), 32'(ctrl0), 32'(vecs[i].exp_ctrl));
      chk($sformatf("vec%0d_ctrl1", i), 32'(ctrl1), 32'(vecs[i].exp_ctrl));
      chk($sformatf("vec%0d_instret0", i), instret0, vecs[i].exp_instret);
      chk($sformatf("vec%0d_instret1", i), 32'(instret1), 32'(vecs[i].exp_instret[3:0]));
    end

    // MUL: dut0 goes through MDU_EXEC/MDU_WAIT, dut1 (no MDU) takes EXECUTER
    starts = 0;
    step(OP_RTYPE, 7'b0000001, 1, 0); starts += int'(ms0);
    chk("mul_fetch_ctrl0", 32'(ctrl0), 32'(C_FETCH_GO));
    chk("mul_fetch_instret0", instret0, 32'd9);
    step(OP_RTYPE, 7'b0000001, 1, 0); starts += int'(ms0);
    chk("mul_decode_ctrl0", 32'(ctrl0), 32'(C_DECODE));
    step(OP_RTYPE, 7'b0000001, 1, 0); starts += int'(ms0);
    chk("mul_exec_ctrl0", 32'(ctrl0), 32'(C_MDU_START));
    chk("mul_nomdu_ctrl1", 32'(ctrl1), 32'(C_EXECR));
    step(OP_RTYPE, 7'b0000001, 1, 0); starts += int'(ms0);
    chk("mul_wait_ctrl0", 32'(ctrl0), 32'(C_ZERO));
    chk("mul_nomdu_wb_ctrl1", 32'(ctrl1), 32'(C_WB));
    for (int k = 0; k < 3; k++) begin
      step(OP_BAD, 7'd0, 1, 0); starts += int'(ms0);
      chk($sformatf("mul_wait%0d_ctrl0", k), 32'(ctrl0), 32'(C_ZERO));
      if (k == 0) chk("mul_nomdu_instret1", 32'(instret1), 32'd10);
    end
    step(OP_BAD, 7'd0, 1, 1); starts += int'(ms0);
    chk("mul_done_cycle_ctrl0", 32'(ctrl0), 32'(C_ZERO));
    step(OP_BAD, 7'd0, 1, 0); starts += int'(ms0);
    chk("mul_aluwb_ctrl0", 32'(ctrl0), 32'(C_WB));
    step(OP_BAD, 7'd0, 0, 0); starts += int'(ms0);
    chk("mul_after_ctrl0", 32'(ctrl0), 32'(C_FETCH_WAIT));
    chk("mul_after_instret0", instret0, 32'd10);
    chk("mul_start_pulses", 32'(starts), 32'd1);
    $display("mul sequence: mdu_start pulses=%0d instret0=%0d", starts, instret0);

    // Async reset while dut0 sits in MDU_WAIT
    do_reset();
    step(OP_RTYPE, 7'b0000001, 1, 0);
    step(OP_RTYPE, 7'b0000001, 1, 0);
    step(OP_RTYPE, 7'b0000001, 1, 0);
    step(OP_RTYPE, 7'b0000001, 1, 0);
    chk("rst_pre_wait_ctrl0", 32'(ctrl0), 32'(C_ZERO));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_wait_ctrl0", 32'(ctrl0), 32'(C_ZERO));
    chk("rst_in_wait_instret0", instret0, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_release_fetch_ctrl0", 32'(ctrl0), 32'(C_FETCH_GO));
    mem_ready = 1'b0;
    $display("reset in MDU_WAIT: ctrl0=%h instret0=%0d", ctrl0, instret0);

    // Illegal opcode after one ADDI: dut0 traps then fetches, dut1 halts
    step(OP_ADDI, 7'd0, 1, 0);
    step(OP_ADDI, 7'd0, 1, 0);
    step(OP_ADDI, 7'd0, 1, 0);
    step(OP_ADDI, 7'd0, 1, 0);
    step(OP_BAD, 7'd0, 1, 0);
    chk("ill_fetch_instret0", instret0, 32'd1);
    step(OP_BAD, 7'd0, 1, 0);
    step(OP_BAD, 7'd0, 1, 0);
    chk("ill_trap_ctrl0", 32'(ctrl0), 32'(C_TRAP));
    chk("ill_trap_ctrl1", 32'(ctrl1), 32'(C_TRAP));
    ills = int'(ill0);
    halts = 0;
    step(OP_ADDI, 7'd0, 0, 0);
    chk("ill_after_ctrl0", 32'(ctrl0), 32'(C_FETCH_WAIT));
    chk("ill_after_instret0", instret0, 32'd1);
    chk("ill_halt_ctrl1", 32'(ctrl1), 32'(C_HALT));
    for (int k = 0; k < 5; k++) begin
      step(OP_ADDI, 7'd0, 1, 1);
      ills += int'(ill0);
      halts += int'(hlt1);
    end
    chk("ill_pulse_count", 32'(ills), 32'd1);
    chk("halt_persist_cycles", 32'(halts), 32'd5);
    chk("halt_instret1", 32'(instret1), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("halt_reset_ctrl1", 32'(ctrl1), 32'(C_ZERO));
    $display("illegal: pulses=%0d halted cycles=%0d", ills, halts);

    // instret wrap on the 4-bit instance
    do_reset();
    for (int j = 0; j < 16; j++) begin
      step(OP_ADDI, 7'd0, 1, 0);
      chk($sformatf("wrap%0d_instret1", j), 32'(instret1), 32'(j));
      step(OP_ADDI, 7'd0, 1, 0);
      step(OP_ADDI, 7'd0, 1, 0);
      step(OP_ADDI, 7'd0, 1, 0);
    end
    step(OP_ADDI, 7'd0, 0, 0);
    chk("wrap_final_instret1", 32'(instret1), 32'd0);
    chk("wrap_final_instret0", instret0, 32'd16);
    $display("wrap: instret0=%0d instret1=%0d", instret0, instret1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
